// File: rtl/flex_counter_pkg.sv
// Shared constants for the flex up/down counter family.
//   COUNT_UP / COUNT_DOWN : encodings of the count_dir input.
//   BOUND_WRAP / BOUND_SAT : encodings of the sat_mode input.
package flex_counter_pkg;

  localparam logic COUNT_UP   = 1'b0;
  localparam logic COUNT_DOWN = 1'b1;

  localparam logic BOUND_WRAP = 1'b0;
  localparam logic BOUND_SAT  = 1'b1;

endpackage : flex_counter_pkg

// File: rtl/flex_counter_next.sv
// Purely combinational next-state logic for flex_updown_counter.
// Ports:
//   count_i        current count
//   sat_i          current saturation state (held when not counting)
//   clear_i        synchronous clear, highest priority
//   load_i         synchronous load, second priority
//   load_val_i     value taken on load
//   count_en_i     advance the count
//   count_dir_i    COUNT_UP / COUNT_DOWN
//   sat_mode_i     BOUND_WRAP / BOUND_SAT
//   rollover_val_i top of the 1..rollover_val range
//   next_count_o   count for the next cycle
//   next_wrap_o    a wrap happens on this step
//   next_sat_o     the counter is held at a boundary on this step
module flex_counter_next
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic [NUM_CNT_BITS-1:0] count_i,
  input  logic                    sat_i,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic [NUM_CNT_BITS-1:0] load_val_i,
  input  logic                    count_en_i,
  input  logic                    count_dir_i,
  input  logic                    sat_mode_i,
  input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
  output logic [NUM_CNT_BITS-1:0] next_count_o,
  output logic                    next_wrap_o,
  output logic                    next_sat_o
);

  localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

  always_comb begin
    next_count_o = count_i;
    next_wrap_o  = 1'b0;
    next_sat_o   = sat_i;

    if (clear_i) begin
      next_count_o = '0;
      next_sat_o   = 1'b0;
    end else if (load_i) begin
      // No range check: a loaded value outside 1..rollover_val is legal.
      next_count_o = load_val_i;
      next_sat_o   = 1'b0;
    end else if (count_en_i) begin
      next_sat_o = 1'b0;
      if (count_dir_i == COUNT_UP) begin
        // Comparing before adding keeps the adder from wrapping at 2^N,
        // and makes a lowered rollover_val take the boundary branch.
        if (count_i < rollover_val_i) begin
          next_count_o = count_i + ONE;
        end else if (sat_mode_i == BOUND_SAT) begin
          next_sat_o = 1'b1;
        end else begin
          next_count_o = ONE;
          next_wrap_o  = 1'b1;
        end
      end else begin
        // count_i of 0 also lands here, so the subtractor never underflows.
        if (count_i > ONE) begin
          next_count_o = count_i - ONE;
        end else if (sat_mode_i == BOUND_SAT) begin
          next_sat_o = 1'b1;
        end else begin
          next_count_o = rollover_val_i;
          next_wrap_o  = 1'b1;
        end
      end
    end
  end

endmodule : flex_counter_next

// File: rtl/flex_updown_counter.sv
// Programmable up/down loop counter with load, wrap-or-saturate boundaries
// and registered event flags. Every output comes straight from a register.
// Ports:
//   clk, n_rst     rising-edge clock, asynchronous active-low reset
//   clear, load    synchronous clear (priority) and parallel load of load_val
//   count_enable   advance this cycle; count_dir 0=up 1=down
//   sat_mode       0=wrap at boundaries, 1=hold at boundaries
//   rollover_val   top of the 1..rollover_val range, sampled every cycle
//   count_out      current count
//   rollover_flag  count_out == rollover_val (as of the last update)
//   bottom_flag    count_out == 1
//   wrap_pulse     one cycle after a wrap
//   sat_flag       holding because of saturation
module flex_updown_counter
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    count_dir,
  input  logic                    sat_mode,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    bottom_flag,
  output logic                    wrap_pulse,
  output logic                    sat_flag
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    roll_q, roll_d;
  logic                    bot_q, bot_d;
  logic                    wrap_q, wrap_d;
  logic                    sat_q, sat_d;

  flex_counter_next #(
    .NUM_CNT_BITS(NUM_CNT_BITS)
  ) u_next (
    .count_i       (count_q),
    .sat_i         (sat_q),
    .clear_i       (clear),
    .load_i        (load),
    .load_val_i    (load_val),
    .count_en_i    (count_enable),
    .count_dir_i   (count_dir),
    .sat_mode_i    (sat_mode),
    .rollover_val_i(rollover_val),
    .next_count_o  (count_d),
    .next_wrap_o   (wrap_d),
    .next_sat_o    (sat_d)
  );

  // Flags are compared against the next count so they line up with
  // count_out in the same edge rather than lagging a cycle.
  assign roll_d = (count_d == rollover_val);
  assign bot_d  = (count_d == NUM_CNT_BITS'(1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      roll_q  <= 1'b0;
      bot_q   <= 1'b0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      roll_q  <= roll_d;
      bot_q   <= bot_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = roll_q;
  assign bottom_flag   = bot_q;
  assign wrap_pulse    = wrap_q;
  assign sat_flag      = sat_q;

endmodule : flex_updown_counter

// File: tb/tb_flex_updown_counter.sv
module tb_flex_updown_counter;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  logic         clear = 0, load = 0, count_enable = 0, count_dir = 0, sat_mode = 0;
  logic [W-1:0] load_val = '0, rollover_val = '0;
  logic [W-1:0] count_out;
  logic         rollover_flag, bottom_flag, wrap_pulse, sat_flag;

  flex_updown_counter #(.NUM_CNT_BITS(W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .count_enable (count_enable),
    .count_dir    (count_dir),
    .sat_mode     (sat_mode),
    .rollover_val (rollover_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag),
    .bottom_flag  (bottom_flag),
    .wrap_pulse   (wrap_pulse),
    .sat_flag     (sat_flag)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- behavioural model ----------------
  // Integer arithmetic over the 1..R range; the model state is the
  // observable output tuple itself.
  int m_cnt = 0;
  bit m_roll = 0, m_bot = 0, m_wrap = 0, m_sat = 0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_cnt <= 0; m_roll <= 0; m_bot <= 0; m_wrap <= 0; m_sat <= 0;
    end else begin
      int c, r;
      bit w, s;
      c = m_cnt; r = int'(rollover_val); w = 0; s = m_sat;
      if (clear) begin
        c = 0; s = 0;
      end else if (load) begin
        c = int'(load_val); s = 0;
      end else if (count_enable) begin
        s = 0;
        if (count_dir == 1'b0) begin
          if (c + 1 <= r)      c = c + 1;
          else if (sat_mode)   s = 1;
          else begin c = 1; w = 1; end
        end else begin
          if (c - 1 >= 1)      c = c - 1;
          else if (sat_mode)   s = 1;
          else begin c = r; w = 1; end
        end
      end
      m_cnt  <= c;
      m_roll <= (c == r);
      m_bot  <= (c == 1);
      m_wrap <= w;
      m_sat  <= s;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model on the falling edge.
  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model.count", int'(count_out), m_cnt);
      chk("model.roll",  int'(rollover_flag), int'(m_roll));
      chk("model.bot",   int'(bottom_flag), int'(m_bot));
      chk("model.wrap",  int'(wrap_pulse), int'(m_wrap));
      chk("model.sat",   int'(sat_flag), int'(m_sat));
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input int c, input int r, input int b,
                         input int w, input int s);
    chk({name, ".count"}, int'(count_out), c);
    chk({name, ".roll"},  int'(rollover_flag), r);
    chk({name, ".bot"},   int'(bottom_flag), b);
    chk({name, ".wrap"},  int'(wrap_pulse), w);
    chk({name, ".sat"},   int'(sat_flag), s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_c[7] = '{1, 2, 3, 4, 5, 1, 2};
    int exp_d[4] = '{2, 1, 5, 4};

    // reset
    #1 n_rst = 1'b0;
    #2 chk_all("reset", 0, 0, 0, 0, 0);
    tick();
    #2 n_rst = 1'b1;
    cmp_en = 1;

    // up, wrap, R=5: 1,2,3,4,5,1,2
    rollover_val = 5; count_dir = 0; sat_mode = 0; count_enable = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("up_wrap", int'(count_out), exp_c[i]);
      chk("up_wrap.roll", int'(rollover_flag), (i == 4) ? 1 : 0);
      chk("up_wrap.wrap", int'(wrap_pulse), (i == 5) ? 1 : 0);
    end

    // down, wrap, R=5: load 3 then 2,1,5,4
    count_enable = 0; load = 1; load_val = 3;
    tick();
    chk_all("load3", 3, 0, 0, 0, 0);
    load = 0; count_dir = 1; count_enable = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("down_wrap", int'(count_out), exp_d[i]);
      chk("down_wrap.bot", int'(bottom_flag), (i == 1) ? 1 : 0);
      chk("down_wrap.wrap", int'(wrap_pulse), (i == 2) ? 1 : 0);
    end

    // up, saturate, R=4: load 3 then 4,4,4,4
    count_dir = 0; sat_mode = 1; rollover_val = 4;
    count_enable = 0; load = 1; load_val = 3;
    tick();
    load = 0; count_enable = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("up_sat", 4, 1, 0, 0, (i >= 1) ? 1 : 0);
    end
    // enable off: sat_flag holds
    count_enable = 0;
    tick();
    chk_all("sat_hold", 4, 1, 0, 0, 1);

    // clear beats load and enable
    clear = 1; load = 1; load_val = 9; count_enable = 1;
    tick();
    chk_all("clear_prio", 0, 0, 0, 0, 0);
    clear = 0;
    tick();
    chk_all("load_prio", 9, 0, 0, 0, 0);

    // rollover_val lowered below the count
    sat_mode = 0; rollover_val = 15; count_enable = 0; load = 1; load_val = 12;
    tick();
    load = 0; rollover_val = 6; count_enable = 1;
    tick();
    chk_all("lowered_R", 1, 0, 1, 1, 0);

    // R=0, up, wrap: always 1 with a wrap, rollover_flag stays 0
    rollover_val = 0; load = 1; load_val = 2; count_enable = 0;
    tick();
    load = 0; count_enable = 1;
    tick();
    chk_all("r0_a", 1, 0, 1, 1, 0);
    tick();
    chk_all("r0_b", 1, 0, 1, 1, 0);

    // R=1: both directions wrap to 1 every cycle
    rollover_val = 1;
    tick();
    chk_all("r1_up", 1, 1, 1, 1, 0);
    count_dir = 1;
    tick();
    chk_all("r1_down", 1, 1, 1, 1, 0);

    // down from 0 in saturate mode holds at 0
    clear = 1; rollover_val = 5;
    tick();
    clear = 0; sat_mode = 1;
    tick();
    chk_all("down_sat0", 0, 0, 0, 0, 1);

    // async reset mid-count at 7
    sat_mode = 0; count_dir = 0; rollover_val = 10;
    count_enable = 0; load = 1; load_val = 6;
    tick();
    load = 0; count_enable = 1;
    tick();
    chk("pre_reset", int'(count_out), 7);
    count_enable = 0;
    #2 n_rst = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0);
    tick();
    #2 n_rst = 1'b1;
    count_enable = 1;
    tick();
    chk("resume1", int'(count_out), 1);
    tick();
    chk("resume2", int'(count_out), 2);

    // random directed mix, checked by the per-cycle model compare
    for (int i = 0; i < 200; i++) begin
      clear        = ($urandom_range(0, 19) == 0);
      load         = ($urandom_range(0, 9) == 0);
      load_val     = W'($urandom_range(0, 15));
      count_enable = ($urandom_range(0, 3) != 0);
      count_dir    = 1'($urandom_range(0, 1));
      sat_mode     = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 15) == 0) rollover_val = W'($urandom_range(0, 15));
      tick();
    end

    @(negedge clk);
    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_flex_updown_counter
